// File: rtl/regfile_read_unit.sv
// Read side of the 32x32 register file: two registered operand read ports with
// write forwarding, plus a valid/ready debug engine that streams every register in order.
//
// state  | meaning
// S_IDLE | waiting for dump_start
// S_SEND | presenting beat dump_idx, advancing on valid && ready
// S_DONE | one-cycle dump_done pulse, dump_start ignored
module regfile_read_unit #(
  parameter int NUM_REGS = 32,
  parameter int WIDTH    = 32,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_clr,
  input  logic [NUM_REGS*WIDTH-1:0] i_reg_bus,
  input  logic                      i_wr_en,
  input  logic [4:0]                i_wr_addr,
  input  logic [WIDTH-1:0]          i_wr_data,
  input  logic                      i_rd_req_a,
  input  logic [4:0]                i_rd_addr_a,
  output logic [WIDTH-1:0]          o_rd_data_a,
  output logic                      o_rd_vld_a,
  input  logic                      i_rd_req_b,
  input  logic [4:0]                i_rd_addr_b,
  output logic [WIDTH-1:0]          o_rd_data_b,
  output logic                      o_rd_vld_b,
  input  logic                      i_dump_start,
  output logic                      o_dump_busy,
  output logic                      o_dump_valid,
  input  logic                      i_dump_ready,
  output logic [4:0]                o_dump_idx,
  output logic [WIDTH-1:0]          o_dump_data,
  output logic                      o_dump_last,
  output logic                      o_dump_done
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rd_data_a, r_rd_data_b, r_dump_data;
  logic             r_rd_vld_a, r_rd_vld_b;
  logic             r_dump_busy, r_dump_valid, r_dump_done;
  logic [4:0]       r_dump_idx;

  logic [WIDTH-1:0] w_regs [NUM_REGS];
  logic [WIDTH-1:0] w_rd_a, w_rd_b, w_rd_next;
  logic [4:0]       w_idx_next;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_unpack
    assign w_regs[g] = i_reg_bus[WIDTH*g +: WIDTH];
  end

  // Index 0 reads as zero and is never forwarded.
  function automatic logic [WIDTH-1:0] f_rd(input logic [4:0] x);
    if (x == 5'd0)                                return '0;
    else if (BYPASS && i_wr_en && i_wr_addr == x) return i_wr_data;
    else                                          return w_regs[x];
  endfunction

  assign w_idx_next = r_dump_idx + 5'd1;

  always_comb begin
    w_rd_a    = f_rd(i_rd_addr_a);
    w_rd_b    = f_rd(i_rd_addr_b);
    w_rd_next = f_rd(w_idx_next);
  end

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_rd_data_a <= '0;
      r_rd_vld_a  <= 1'b0;
      r_rd_data_b <= '0;
      r_rd_vld_b  <= 1'b0;
    end else begin
      r_rd_vld_a <= i_rd_req_a;
      r_rd_vld_b <= i_rd_req_b;
      if (i_rd_req_a) r_rd_data_a <= w_rd_a;
      if (i_rd_req_b) r_rd_data_b <= w_rd_b;
    end
  end

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_state      <= S_IDLE;
      r_dump_idx   <= '0;
      r_dump_data  <= '0;
      r_dump_busy  <= 1'b0;
      r_dump_valid <= 1'b0;
      r_dump_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_dump_done <= 1'b0;
          if (i_dump_start) begin
            r_state      <= S_SEND;
            r_dump_idx   <= '0;
            r_dump_data  <= '0;
            r_dump_busy  <= 1'b1;
            r_dump_valid <= 1'b1;
          end
        end
        S_SEND: begin
          if (i_dump_ready) begin
            if (r_dump_idx == LAST_IDX) begin
              r_state      <= S_DONE;
              r_dump_busy  <= 1'b0;
              r_dump_valid <= 1'b0;
              r_dump_done  <= 1'b1;
            end else begin
              r_dump_idx  <= w_idx_next;
              r_dump_data <= w_rd_next;
            end
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_dump_done <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_dump_busy  <= 1'b0;
          r_dump_valid <= 1'b0;
          r_dump_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_rd_data_a  = r_rd_data_a;
  assign o_rd_vld_a   = r_rd_vld_a;
  assign o_rd_data_b  = r_rd_data_b;
  assign o_rd_vld_b   = r_rd_vld_b;
  assign o_dump_busy  = r_dump_busy;
  assign o_dump_valid = r_dump_valid;
  assign o_dump_idx   = r_dump_idx;
  assign o_dump_data  = r_dump_data;
  assign o_dump_done  = r_dump_done;
  assign o_dump_last  = r_dump_valid && (r_dump_idx == LAST_IDX);

endmodule
